// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared op codes, FSM states and op classification for seq_alu
package seq_alu_pkg;
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b1010,
    ALU_SLT  = 4'b1011,
    ALU_ROR  = 4'b0100,
    ALU_ROL  = 4'b0101,
    ALU_NOR  = 4'b0110,
    ALU_MUL  = 4'b0111,
    ALU_DIVU = 4'b1111
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  function automatic logic is_iter(input logic [3:0] f);
    return f == ALU_MUL || f == ALU_DIVU;
  endfunction
endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: one-bit-per-cycle shift-add multiplier / restoring divider
module seq_alu_muldiv import seq_alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] hr, lr, br;
  logic [SHW-1:0]   cnt;
  logic             active, is_div;
  logic [WIDTH:0]   mul_sum, div_t;
  logic [WIDTH-1:0] div_d;
  logic             div_ge;
  // hi/lo present the value after the step taken on the coming edge, so the
  // parent can capture the final result on the same edge as the last step
  always_comb begin
    mul_sum = {1'b0, hr} + (lr[0] ? {1'b0, br} : '0);
    div_t   = {hr, lr[WIDTH-1]};
    div_ge  = div_t >= {1'b0, br};
    div_d   = div_t[WIDTH-1:0] - br;
    hi      = is_div ? (div_ge ? div_d : div_t[WIDTH-1:0]) : mul_sum[WIDTH:1];
    lo      = is_div ? {lr[WIDTH-2:0], div_ge} : {mul_sum[0], lr[WIDTH-1:1]};
    done    = active && cnt == SHW'(WIDTH-1);
  end
  // hr/lr hold {partial product, multiplier} or {remainder, dividend/quotient}
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hr     <= '0;
      lr     <= '0;
      br     <= '0;
      cnt    <= '0;
      active <= 1'b0;
      is_div <= 1'b0;
    end else if (start) begin
      hr     <= '0;
      lr     <= a;
      br     <= b;
      cnt    <= '0;
      active <= 1'b1;
      is_div <= op == ALU_DIVU;
    end else if (active) begin
      hr     <= hi;
      lr     <= lo;
      cnt    <= cnt + 1'b1;
      active <= !done;
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: valid/ready ALU with single-cycle logic/arith ops and iterative MUL/DIVU
module seq_alu import seq_alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  state_t             state, state_nx;
  logic               accept, start, md_done;
  logic [WIDTH-1:0]   md_hi, md_lo, alu_y;
  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] rr, rl;
  assign in_ready  = state == IDLE;
  assign busy      = state == ITER;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign start     = accept && is_iter(f);
  assign amt       = a[SHW-1:0];
  assign rr        = {b, b} >> amt;
  assign rl        = {b, b} << amt;
  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk(clk), .reset_n(reset_n), .start(start), .op(f), .a(a), .b(b),
    .done(md_done), .hi(md_hi), .lo(md_lo)
  );
  // single-cycle result; codes without a defined op produce 0
  always_comb begin
    alu_y = '0;
    case (f)
      ALU_AND: alu_y = a & b;
      ALU_OR:  alu_y = a | b;
      ALU_ADD: alu_y = a + b;
      ALU_SUB: alu_y = a + ~b + 1'b1;
      ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_ROR: alu_y = rr[WIDTH-1:0];
      ALU_ROL: alu_y = rl[2*WIDTH-1:WIDTH];
      ALU_NOR: alu_y = ~(a | b);
      default: alu_y = '0;
    endcase
  end
  // next state: consuming a result returns to IDLE, so no same-cycle re-accept
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept ? (is_iter(f) ? ITER : DONE) : IDLE)
             : state == ITER ? (md_done ? DONE : ITER)
             : (out_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // result registers load only when a result is produced, so they hold in DONE
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      y    <= '0;
      hi   <= '0;
      zero <= 1'b0;
    end else if (accept && !is_iter(f)) begin
      y    <= alu_y;
      hi   <= '0;
      zero <= alu_y == '0;
    end else if (state == ITER && md_done) begin
      y    <= md_lo;
      hi   <= md_hi;
      zero <= md_lo == '0;
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=32
module tb_seq_alu;
  import seq_alu_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  f = '0;
  logic        in_ready, out_valid, zero, busy;
  logic [31:0] y, hi;
  int checks = 0;
  int failures = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .hi(hi), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    chk1({tag, " in_ready"}, in_ready, 1'b1);
    f = op;
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    f = 4'b0011;
  endtask

  task automatic await(input string tag, input int lat, input logic [31:0] ey, input logic [31:0] eh);
    int n = 0;
    int bad = 0;
    while (!out_valid && n < 100) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy/in_ready while iterating"}, bad, 0);
    chk1({tag, " out_valid"}, out_valid, 1'b1);
    chk({tag, " y"}, y, ey);
    chk({tag, " hi"}, hi, eh);
    chk1({tag, " zero"}, zero, ey == 32'd0);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk1({tag, " out_valid after consume"}, out_valid, 1'b0);
    chk1({tag, " in_ready after consume"}, in_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                     input int lat, input logic [31:0] ey, input logic [31:0] eh);
    issue(tag, op, va, vb);
    await(tag, lat, ey, eh);
    consume(tag);
  endtask

  initial begin
    int seen;
    #1;
    chk1("reset in_ready", in_ready, 1'b1);
    chk1("reset out_valid", out_valid, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk("reset y", y, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk1("reset zero", zero, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run("add", ALU_ADD, 32'd5, 32'd7, 0, 32'd12, 32'd0);
    run("sub", ALU_SUB, 32'd7, 32'd7, 0, 32'd0, 32'd0);
    run("sub_wrap", ALU_SUB, 32'd3, 32'd5, 0, 32'hFFFFFFFE, 32'd0);
    run("add_wrap", ALU_ADD, 32'hFFFFFFFF, 32'd2, 0, 32'd1, 32'd0);
    run("ror4", ALU_ROR, 32'd4, 32'h0000000F, 0, 32'hF0000000, 32'd0);
    run("rol0", ALU_ROL, 32'd0, 32'h80000001, 0, 32'h80000001, 32'd0);
    run("ror36", ALU_ROR, 32'd36, 32'd1, 0, 32'h10000000, 32'd0);
    run("rol4", ALU_ROL, 32'd4, 32'h80000001, 0, 32'h00000018, 32'd0);
    run("and", ALU_AND, 32'h0000F0F0, 32'h0000FF00, 0, 32'h0000F000, 32'd0);
    run("or", ALU_OR, 32'h0000F0F0, 32'h0000FF00, 0, 32'h0000FFF0, 32'd0);
    run("nor", ALU_NOR, 32'd0, 32'd0, 0, 32'hFFFFFFFF, 32'd0);
    run("undef", 4'b0011, 32'd5, 32'd7, 0, 32'd0, 32'd0);
    run("slt_false", ALU_SLT, 32'd5, 32'hFFFFFFFD, 0, 32'd0, 32'd0);
    run("mul", ALU_MUL, 32'hFFFFFFFF, 32'd2, 32, 32'hFFFFFFFE, 32'd1);
    run("mul_max", ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'd1, 32'hFFFFFFFE);
    run("divu", ALU_DIVU, 32'd100, 32'd7, 32, 32'd14, 32'd2);
    run("divu0", ALU_DIVU, 32'd9, 32'd0, 32, 32'hFFFFFFFF, 32'd9);

    issue("mul_abort", ALU_MUL, 32'hFFFFFFFF, 32'd2);
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk1("abort out_valid", out_valid, 1'b0);
    chk1("abort busy", busy, 1'b0);
    chk1("abort in_ready", in_ready, 1'b1);
    chk("abort y", y, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk1("abort zero", zero, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("abort no result delivered", seen, 0);
    run("add_after_reset", ALU_ADD, 32'd1, 32'd1, 0, 32'd2, 32'd0);

    issue("slt_hold", ALU_SLT, 32'hFFFFFFFF, 32'd1);
    await("slt_hold", 0, 32'd1, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      f = ALU_ADD;
      a = 32'd3;
      b = 32'd4;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("slt_hold y", y, 32'd1);
      chk1("slt_hold out_valid", out_valid, 1'b1);
      chk1("slt_hold in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk1("slt_hold consumed", out_valid, 1'b0);
    chk1("slt_hold idle", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk1("no accept on consume edge", out_valid, 1'b0);
    chk("y held after consume", y, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of two, 8..64).
REQ-002 SHALL have localparam SHW = log2(WIDTH), the rotate-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A (rotate amount for ROR/ROL).
REQ-008 b  input  WIDTH  operand B (value rotated for ROR/ROL).
REQ-009 f  input  4  operation code (seq_alu_pkg::alu_op_t).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 y  output  WIDTH  primary result (low product, quotient, or logic/arith result).
REQ-013 hi  output  WIDTH  secondary result (high product, remainder, else 0).
REQ-014 zero  output  1  y equals 0.
REQ-015 busy  output  1  multi-cycle MUL/DIVU iteration in progress.

Function
REQ-016 Op codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 1010 SUB, 1011 SLT (signed, 1 if a<b), 0100 ROR, 0101 ROL, 0110 NOR, 0111 MUL, 1111 DIVU; all other codes yield y=0, hi=0.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; SUB = a + ~b + 1.
REQ-018 ROR/ROL SHALL rotate b by a[SHW-1:0]; amount 0 returns b unchanged; upper bits of a ignored.
REQ-019 MUL SHALL be unsigned WIDTH x WIDTH -> 2*WIDTH, iterative shift-add, one partial step per cycle, {hi,y} = product.
REQ-020 DIVU SHALL be unsigned restoring division, one quotient bit per cycle, y = quotient, hi = remainder.
REQ-021 DIVU with b=0 SHALL give y = all ones, hi = a, same latency as a normal DIVU.
REQ-022 FSM states SHALL be IDLE, ITER, DONE.
REQ-023 in_ready SHALL equal (state==IDLE); a request is accepted on an edge where in_valid && in_ready.
REQ-024 Single-cycle ops: IDLE -> DONE on acceptance; out_valid high from the next cycle.
REQ-025 MUL/DIVU: IDLE -> ITER on acceptance; iteration counter counts WIDTH steps; ITER -> DONE after WIDTH-th step; out_valid high exactly WIDTH cycles after the accepting edge.
REQ-026 busy SHALL equal (state==ITER); operands SHALL be latched at acceptance, input changes afterwards have no effect.
REQ-027 DONE -> IDLE on edge with out_ready; y, hi, zero SHALL hold stable while out_valid && !out_ready.
REQ-028 No new request SHALL be accepted in the same cycle a result is consumed (one-op-in-flight, no bypass).
REQ-029 zero SHALL be registered with y and valid whenever out_valid is high.

Reset
REQ-030 reset_n low SHALL immediately force state=IDLE, counter=0, y=0, hi=0, zero=0, out_valid=0, busy=0, in_ready=1.
REQ-031 Reset during ITER or DONE SHALL abort the operation with no result delivered; first accept possible on the first edge after reset_n rises.

Structure
REQ-032 Package seq_alu_pkg SHALL hold alu_op_t enum (4-bit codes above) and state_t enum.
REQ-033 Iterative multiply/divide datapath SHALL be sub-module seq_alu_muldiv (start, op, operands in; done, hi, lo out); single-cycle ops stay in seq_alu.

Verification (WIDTH=32)
REQ-034 ADD a=5 b=7 -> out_valid next cycle, y=12, hi=0, zero=0; SUB a=7 b=7 -> y=0, zero=1.
REQ-035 ROR a=4 b=0x0000000F -> y=0xF0000000; ROL a=0 b=0x80000001 -> y=0x80000001; ROR a=36 b=1 -> y=0x10000000.
REQ-036 MUL a=0xFFFFFFFF b=2 -> after 32 cycles y=0xFFFFFFFE, hi=1; in_ready=0 and busy=1 throughout.
REQ-037 DIVU a=100 b=7 -> y=14, hi=2 after 32 cycles; DIVU a=9 b=0 -> y=0xFFFFFFFF, hi=9.
REQ-038 out_ready low 3 cycles after SLT a=-1 b=1 -> y=1 held, in_ready=0, in_valid ignored; consumed on 4th cycle.
REQ-039 reset_n pulsed low at MUL step 10 -> outputs zero at once, no out_valid; next ADD 1+1 gives y=2 normally.
